// File: rtl/pipe_hazard_ctrl.sv
// Pipelined-ARM control path: D/E/M/W control registers, condition check,
// flag register, and hazard unit (forwarding, load-use stall, PC-write flushes).
module pipe_hazard_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       RegWriteD,
  input  logic       MemtoRegD,
  input  logic       MemWriteD,
  input  logic       PCSrcD,
  input  logic       BranchD,
  input  logic [1:0] FlagWriteD,
  input  logic [3:0] CondD,
  input  logic [3:0] ALUFlags,
  input  logic [3:0] RA1D,
  input  logic [3:0] RA2D,
  input  logic [3:0] RA1E,
  input  logic [3:0] RA2E,
  input  logic [3:0] WA3E,
  input  logic [3:0] WA3M,
  input  logic [3:0] WA3W,
  output logic       StallF,
  output logic       StallD,
  output logic       FlushD,
  output logic       FlushE,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       BranchTakenE,
  output logic       MemWriteM,
  output logic       RegWriteW,
  output logic       MemtoRegW,
  output logic       PCSrcW,
  output logic [3:0] FlagsQ
);

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000, COND_NE = 4'b0001, COND_CS = 4'b0010, COND_CC = 4'b0011,
    COND_MI = 4'b0100, COND_PL = 4'b0101, COND_VS = 4'b0110, COND_VC = 4'b0111,
    COND_HI = 4'b1000, COND_LS = 4'b1001, COND_GE = 4'b1010, COND_LT = 4'b1011,
    COND_GT = 4'b1100, COND_LE = 4'b1101, COND_AL = 4'b1110, COND_NV = 4'b1111
  } cond_t;

  typedef enum logic [1:0] {
    FWD_RF      = 2'b00,
    FWD_RESULTW = 2'b01,
    FWD_ALUOUTM = 2'b10
  } fwd_t;

  logic       reg_write_e, memto_reg_e, mem_write_e, pc_src_e, branch_e;
  logic [1:0] flag_write_e;
  cond_t      cond_e;
  logic       reg_write_m, memto_reg_m, pc_src_m;
  logic       cond_ex_e;
  logic       ld_stall;
  logic       pc_wr_pend;
  logic       flag_n, flag_z, flag_c, flag_v;

  assign {flag_n, flag_z, flag_c, flag_v} = FlagsQ;

  always_comb begin
    cond_ex_e = 1'b1;
    case (cond_e)
      COND_EQ: cond_ex_e = flag_z;
      COND_NE: cond_ex_e = ~flag_z;
      COND_CS: cond_ex_e = flag_c;
      COND_CC: cond_ex_e = ~flag_c;
      COND_MI: cond_ex_e = flag_n;
      COND_PL: cond_ex_e = ~flag_n;
      COND_VS: cond_ex_e = flag_v;
      COND_VC: cond_ex_e = ~flag_v;
      COND_HI: cond_ex_e = flag_c & ~flag_z;
      COND_LS: cond_ex_e = ~flag_c | flag_z;
      COND_GE: cond_ex_e = (flag_n == flag_v);
      COND_LT: cond_ex_e = (flag_n != flag_v);
      COND_GT: cond_ex_e = ~flag_z & (flag_n == flag_v);
      COND_LE: cond_ex_e = flag_z | (flag_n != flag_v);
      default: cond_ex_e = 1'b1;
    endcase
  end

  function automatic fwd_t fwd_sel(input logic [3:0] ra, input logic wr_m,
                                   input logic [3:0] wa_m, input logic wr_w,
                                   input logic [3:0] wa_w);
    if (wr_m && (ra == wa_m))
      return FWD_ALUOUTM;
    else if (wr_w && (ra == wa_w))
      return FWD_RESULTW;
    else
      return FWD_RF;
  endfunction

  // Load-use detection uses the ungated E-stage RegWrite: the condition of a
  // load is not known early enough to skip the bubble.
  always_comb begin
    BranchTakenE = branch_e & cond_ex_e;
    ld_stall     = memto_reg_e & reg_write_e & ((RA1D == WA3E) | (RA2D == WA3E));
    pc_wr_pend   = PCSrcD | (pc_src_e & cond_ex_e) | pc_src_m;
    StallD       = ld_stall;
    StallF       = ld_stall | pc_wr_pend;
    FlushD       = pc_wr_pend | PCSrcW | BranchTakenE;
    FlushE       = ld_stall | BranchTakenE;
    ForwardAE    = fwd_sel(RA1E, reg_write_m, WA3M, RegWriteW, WA3W);
    ForwardBE    = fwd_sel(RA2E, reg_write_m, WA3M, RegWriteW, WA3W);
  end

  always_ff @(posedge clk) begin
    if (reset || FlushE) begin
      reg_write_e  <= 1'b0;
      memto_reg_e  <= 1'b0;
      mem_write_e  <= 1'b0;
      pc_src_e     <= 1'b0;
      branch_e     <= 1'b0;
      flag_write_e <= '0;
      cond_e       <= COND_EQ;
    end else begin
      reg_write_e  <= RegWriteD;
      memto_reg_e  <= MemtoRegD;
      mem_write_e  <= MemWriteD;
      pc_src_e     <= PCSrcD;
      branch_e     <= BranchD;
      flag_write_e <= FlagWriteD;
      cond_e       <= cond_t'(CondD);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      reg_write_m <= 1'b0;
      memto_reg_m <= 1'b0;
      MemWriteM   <= 1'b0;
      pc_src_m    <= 1'b0;
      RegWriteW   <= 1'b0;
      MemtoRegW   <= 1'b0;
      PCSrcW      <= 1'b0;
      FlagsQ      <= '0;
    end else begin
      reg_write_m <= reg_write_e & cond_ex_e;
      memto_reg_m <= memto_reg_e;
      MemWriteM   <= mem_write_e & cond_ex_e;
      pc_src_m    <= pc_src_e & cond_ex_e;
      RegWriteW   <= reg_write_m;
      MemtoRegW   <= memto_reg_m;
      PCSrcW      <= pc_src_m;
      if (flag_write_e[1] && cond_ex_e)
        FlagsQ[3:2] <= ALUFlags[3:2];
      if (flag_write_e[0] && cond_ex_e)
        FlagsQ[1:0] <= ALUFlags[1:0];
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against an instruction-level model.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       RegWriteD, MemtoRegD, MemWriteD, PCSrcD, BranchD;
  logic [1:0] FlagWriteD;
  logic [3:0] CondD, ALUFlags;
  logic [3:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
  logic       StallF, StallD, FlushD, FlushE;
  logic [1:0] ForwardAE, ForwardBE;
  logic       BranchTakenE, MemWriteM, RegWriteW, MemtoRegW, PCSrcW;
  logic [3:0] FlagsQ;

  int unsigned checks = 0;
  int unsigned errors = 0;

  pipe_hazard_ctrl dut (
    .clk(clk), .reset(reset),
    .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .MemWriteD(MemWriteD),
    .PCSrcD(PCSrcD), .BranchD(BranchD), .FlagWriteD(FlagWriteD),
    .CondD(CondD), .ALUFlags(ALUFlags),
    .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .BranchTakenE(BranchTakenE), .MemWriteM(MemWriteM),
    .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW), .PCSrcW(PCSrcW),
    .FlagsQ(FlagsQ)
  );

  always #5 clk = ~clk;

  // One instruction's control word as it travels down the pipe.
  typedef struct packed {
    logic       rw, m2r, mw, pcs, br;
    logic [1:0] fw;
    logic [3:0] cond;
  } instr_t;

  instr_t     pipe [3];   // 0 = E, 1 = M, 2 = W
  logic [3:0] m_flags;

  // ARM rule: cond[3:1] picks a base test, cond[0] inverts it, 111x always runs.
  function automatic bit passes(input logic [3:0] cc, input logic [3:0] f);
    bit n, z, c, v, base;
    {n, z, c, v} = f;
    case (cc[3:1])
      3'd0: base = z;
      3'd1: base = c;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = c && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    if (cc[3:1] == 3'd7) return 1'b1;
    return base ^ cc[0];
  endfunction

  function automatic logic [1:0] fwd(input logic [3:0] ra);
    if (pipe[1].rw && ra == WA3M) return 2'd2;
    if (pipe[2].rw && ra == WA3W) return 2'd1;
    return 2'd0;
  endfunction

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_check();
    bit ex, taken, ld, pend;
    ex    = passes(pipe[0].cond, m_flags);
    taken = pipe[0].br && ex;
    ld    = pipe[0].m2r && pipe[0].rw && (RA1D == WA3E || RA2D == WA3E);
    pend  = PCSrcD || (pipe[0].pcs && ex) || pipe[1].pcs;
    chk("m_StallF",    {3'b0, StallF},       {3'b0, ld || pend});
    chk("m_StallD",    {3'b0, StallD},       {3'b0, ld});
    chk("m_FlushD",    {3'b0, FlushD},       {3'b0, pend || pipe[2].pcs || taken});
    chk("m_FlushE",    {3'b0, FlushE},       {3'b0, ld || taken});
    chk("m_ForwardAE", {2'b0, ForwardAE},    {2'b0, fwd(RA1E)});
    chk("m_ForwardBE", {2'b0, ForwardBE},    {2'b0, fwd(RA2E)});
    chk("m_BranchTkn", {3'b0, BranchTakenE}, {3'b0, taken});
    chk("m_MemWriteM", {3'b0, MemWriteM},    {3'b0, pipe[1].mw});
    chk("m_RegWriteW", {3'b0, RegWriteW},    {3'b0, pipe[2].rw});
    chk("m_MemtoRegW", {3'b0, MemtoRegW},    {3'b0, pipe[2].m2r});
    chk("m_PCSrcW",    {3'b0, PCSrcW},       {3'b0, pipe[2].pcs});
    chk("m_FlagsQ",    FlagsQ,               m_flags);
  endtask

  task automatic model_advance();
    bit ex, taken, ld;
    instr_t d, g;
    if (reset) begin
      for (int i = 0; i < 3; i++) pipe[i] = '0;
      m_flags = '0;
      return;
    end
    ex    = passes(pipe[0].cond, m_flags);
    taken = pipe[0].br && ex;
    ld    = pipe[0].m2r && pipe[0].rw && (RA1D == WA3E || RA2D == WA3E);
    d     = '{RegWriteD, MemtoRegD, MemWriteD, PCSrcD, BranchD, FlagWriteD, CondD};
    g     = pipe[0];
    g.rw  = g.rw && ex;
    g.mw  = g.mw && ex;
    g.pcs = g.pcs && ex;
    if (ex && pipe[0].fw[1]) m_flags[3:2] = ALUFlags[3:2];
    if (ex && pipe[0].fw[0]) m_flags[1:0] = ALUFlags[1:0];
    pipe[2] = pipe[1];
    pipe[1] = g;
    pipe[0] = (ld || taken) ? instr_t'('0) : d;
  endtask

  task automatic tick();
    @(negedge clk);
    model_check();
    @(posedge clk);
    model_advance();
    #1;
  endtask

  task automatic clr_d();
    RegWriteD = 0; MemtoRegD = 0; MemWriteD = 0; PCSrcD = 0; BranchD = 0;
    FlagWriteD = '0; CondD = 4'hE;
  endtask

  task automatic clr_addr();
    RA1D = 4'd0; RA2D = 4'd0; RA1E = 4'd0; RA2E = 4'd0;
    WA3E = 4'd9; WA3M = 4'd10; WA3W = 4'd11;
  endtask

  task automatic rand_inputs();
    reset      = ($urandom_range(0, 59) == 0);
    RegWriteD  = 1'($urandom);
    MemtoRegD  = ($urandom_range(0, 2) == 0);
    MemWriteD  = ($urandom_range(0, 3) == 0);
    PCSrcD     = ($urandom_range(0, 9) == 0);
    BranchD    = ($urandom_range(0, 4) == 0);
    FlagWriteD = 2'($urandom);
    CondD      = 4'($urandom);
    ALUFlags   = 4'($urandom);
    RA1D = 4'($urandom_range(0, 3)); RA2D = 4'($urandom_range(0, 3));
    RA1E = 4'($urandom_range(0, 3)); RA2E = 4'($urandom_range(0, 3));
    WA3E = 4'($urandom_range(0, 3)); WA3M = 4'($urandom_range(0, 3));
    WA3W = 4'($urandom_range(0, 3));
  endtask

  initial begin
    for (int i = 0; i < 3; i++) pipe[i] = '0;
    m_flags = '0;
    clr_d(); clr_addr(); ALUFlags = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("rst_StallF", {3'b0, StallF}, 4'h0);
    chk("rst_FlushD", {3'b0, FlushD}, 4'h0);
    chk("rst_FlushE", {3'b0, FlushE}, 4'h0);
    chk("rst_FwdA",   {2'b0, ForwardAE}, 4'h0);
    chk("rst_Flags",  FlagsQ, 4'h0);

    // ADD R1, then a consumer of R1 in E (M forward), then one cycle later (W forward)
    RegWriteD = 1; tick(); clr_d();
    WA3E = 4'd1; tick();
    WA3M = 4'd1; RA1E = 4'd1; #1 chk("add_fwdA_M", {2'b0, ForwardAE}, 4'h2); tick();
    WA3M = 4'd10; WA3W = 4'd1; RA1E = 4'd1; #1 chk("add_fwdA_W", {2'b0, ForwardAE}, 4'h1);
    tick(); clr_addr();

    // LDR R2 followed by ADD reading R2
    RegWriteD = 1; MemtoRegD = 1; tick();
    clr_d(); RegWriteD = 1; WA3E = 4'd2; RA2D = 4'd2; #1;
    chk("ld_StallF", {3'b0, StallF}, 4'h1);
    chk("ld_StallD", {3'b0, StallD}, 4'h1);
    chk("ld_FlushE", {3'b0, FlushE}, 4'h1);
    tick();
    #1 chk("ld_once_StallD", {3'b0, StallD}, 4'h0);
    chk("ld_once_FlushE", {3'b0, FlushE}, 4'h0);
    tick(); clr_d(); clr_addr();
    RA2E = 4'd2; WA3W = 4'd2; #1 chk("ld_fwdB_W", {2'b0, ForwardBE}, 4'h1);
    tick(); clr_addr();

    // CMP sets Z, BEQ taken, BNE not taken
    FlagWriteD = 2'b11; tick();
    clr_d(); ALUFlags = 4'b0100; BranchD = 1; CondD = 4'h0; tick();
    clr_d(); ALUFlags = 4'b0000; #1;
    chk("beq_taken",  {3'b0, BranchTakenE}, 4'h1);
    chk("beq_FlushD", {3'b0, FlushD}, 4'h1);
    chk("beq_FlushE", {3'b0, FlushE}, 4'h1);
    chk("cmp_flags",  FlagsQ, 4'h4);
    tick();
    #1 chk("beq_one_cycle", {3'b0, FlushD}, 4'h0);
    BranchD = 1; CondD = 4'h1; tick(); clr_d();
    #1 chk("bne_not_taken", {3'b0, BranchTakenE}, 4'h0);
    tick();

    // Write to R15: StallF three cycles, FlushD four, PCSrcW on the fourth
    PCSrcD = 1; RegWriteD = 1; #1;
    chk("pc1_StallF", {3'b0, StallF}, 4'h1); chk("pc1_FlushD", {3'b0, FlushD}, 4'h1);
    tick(); clr_d(); #1;
    chk("pc2_StallF", {3'b0, StallF}, 4'h1); chk("pc2_FlushD", {3'b0, FlushD}, 4'h1);
    tick(); #1;
    chk("pc3_StallF", {3'b0, StallF}, 4'h1); chk("pc3_PCSrcW", {3'b0, PCSrcW}, 4'h0);
    tick(); #1;
    chk("pc4_StallF", {3'b0, StallF}, 4'h0); chk("pc4_FlushD", {3'b0, FlushD}, 4'h1);
    chk("pc4_PCSrcW", {3'b0, PCSrcW}, 4'h1);
    tick(); #1;
    chk("pc5_FlushD", {3'b0, FlushD}, 4'h0);

    // Clear Z, then STR EQ is suppressed while STR AL writes
    FlagWriteD = 2'b11; tick(); clr_d(); ALUFlags = 4'b0000; tick();
    MemWriteD = 1; CondD = 4'h0; tick(); clr_d(); tick();
    #1 chk("streq_MemWriteM", {3'b0, MemWriteM}, 4'h0);
    MemWriteD = 1; tick(); clr_d(); tick();
    #1 chk("stral_MemWriteM", {3'b0, MemWriteM}, 4'h1);
    tick();

    // Reset while a taken branch sits in E
    BranchD = 1; CondD = 4'h1; tick(); clr_d();
    #1 chk("bne_taken_pre_rst", {3'b0, BranchTakenE}, 4'h1);
    reset = 1; tick(); reset = 0; #1;
    chk("rst_mid_Branch", {3'b0, BranchTakenE}, 4'h0);
    chk("rst_mid_FlushD", {3'b0, FlushD}, 4'h0);
    chk("rst_mid_FlushE", {3'b0, FlushE}, 4'h0);
    chk("rst_mid_StallF", {3'b0, StallF}, 4'h0);
    chk("rst_mid_MemWrM", {3'b0, MemWriteM}, 4'h0);
    chk("rst_mid_RegWrW", {3'b0, RegWriteW}, 4'h0);
    tick();

    // Randomized traffic, every cycle compared against the model
    for (int n = 0; n < 3000; n++) begin
      rand_inputs();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have no parameters; all widths fixed.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 RegWriteD  in  1  decoded register write, D stage.
REQ-005 MemtoRegD  in  1  decoded load (writeback from memory), D stage.
REQ-006 MemWriteD  in  1  decoded store, D stage.
REQ-007 PCSrcD  in  1  instruction writes R15 through writeback, D stage.
REQ-008 BranchD  in  1  instruction is a branch, D stage.
REQ-009 FlagWriteD  in  2  [1] updates N,Z; [0] updates C,V; D stage.
REQ-010 CondD  in  4  condition field of D-stage instruction.
REQ-011 ALUFlags  in  4  ALU flags {N,Z,C,V} from E stage, combinational.
REQ-012 RA1D / RA2D  in  4 each  D-stage source register addresses (one port each).
REQ-013 RA1E / RA2E  in  4 each  E-stage source register addresses (one port each).
REQ-014 WA3E / WA3M / WA3W  in  4 each  destination address in E, M, W (one port each).
REQ-015 StallF / StallD  out  1 each  hold PC / hold F-D register.
REQ-016 FlushD / FlushE  out  1 each  clear F-D / D-E register next edge.
REQ-017 ForwardAE / ForwardBE  out  2 each  operand select: 00 register file, 01 ResultW, 10 ALUOutM.
REQ-018 BranchTakenE  out  1  select ALU result as next PC.
REQ-019 MemWriteM  out  1  data memory write enable, M stage.
REQ-020 RegWriteW / MemtoRegW / PCSrcW  out  1 each  writeback controls, W stage.
REQ-021 FlagsQ  out  4  architectural {N,Z,C,V} register.

Function
REQ-022 Control pipeline: D->E register holds {RegWrite, MemtoReg, MemWrite, PCSrc, Branch, FlagWrite, Cond}; E->M holds {RegWrite, MemtoReg, MemWrite, PCSrc}; M->W holds {RegWrite, MemtoReg, PCSrc}.
REQ-023 D->E register SHALL load zero when FlushE=1, else D values; E->M and M->W SHALL load every cycle, never stalled.
REQ-024 CondExE SHALL evaluate CondE against FlagsQ: EQ Z, NE ~Z, CS C, CC ~C, MI N, PL ~N, VS V, VC ~V, HI C&~Z, LS ~C|Z, GE N==V, LT N!=V, GT ~Z&(N==V), LE Z|(N!=V), 1110 and 1111 always true.
REQ-025 RegWrite, MemWrite, PCSrc entering E->M SHALL be ANDed with CondExE; MemtoReg passes ungated.
REQ-026 FlagsQ[3:2] SHALL load ALUFlags[3:2] when FlagWriteE[1]&CondExE; FlagsQ[1:0] likewise with FlagWriteE[0]; otherwise hold.
REQ-027 BranchTakenE = BranchE & CondExE, combinational.
REQ-028 ForwardAE = 10 if RegWriteM & RA1E==WA3M; else 01 if RegWriteW & RA1E==WA3W; else 00. M match wins over W. ForwardBE identical using RA2E.
REQ-029 LdStall = MemtoRegE & RegWriteE & (RA1D==WA3E | RA2D==WA3E); RegWriteE is ungated; one-cycle bubble per load-use.
REQ-030 PCWrPend = PCSrcD | PCSrcE | PCSrcM (each stage's PCSrc; E and M values after REQ-025 gating).
REQ-031 StallD = LdStall; StallF = LdStall | PCWrPend.
REQ-032 FlushD = PCWrPend | PCSrcW | BranchTakenE; FlushE = LdStall | BranchTakenE.
REQ-033 LdStall and BranchTakenE in same cycle: both asserted per equations; FlushE=1 dominates and E gets a bubble.
REQ-034 All outputs not registered SHALL be purely combinational from current state and inputs; no latches.

Reset
REQ-035 While reset=1 at a clock edge, all pipeline control registers and FlagsQ SHALL clear to 0; reset during a pending branch or PC write discards it.
REQ-036 After reset: StallF=StallD=FlushD=FlushE=0, ForwardAE=ForwardBE=00, BranchTakenE=0, all W/M enables 0.

Verification
REQ-037 ADD R1 (RegWriteD=1, WA3=1) then SUB reading RA1E=1 next cycle -> ForwardAE=10; one cycle later RA1E=1 -> ForwardAE=01.
REQ-038 LDR R2 then ADD with RA2D=2 -> StallF=StallD=1 and FlushE=1 for exactly one cycle, then ForwardBE=01.
REQ-039 CMP setting FlagWrite=11 with ALUFlags=0100, then BEQ (CondD=0000, BranchD=1) -> BranchTakenE=1, FlushD=FlushE=1 one cycle; BNE same flags -> BranchTakenE=0.
REQ-040 PCSrcD=1 (write to R15) -> StallF=1 for three cycles, FlushD=1 for four cycles, PCSrcW=1 on fourth.
REQ-041 STR with CondD=0000 and FlagsQ Z=0 -> MemWriteM=0; reset asserted mid-branch -> all outputs at reset values next cycle.
